decrypt_ctrl_fsm: RTL

- Control FSM for the AES-128 decryption path; the inverse-direction counterpart of the encryption controller.
- Drives the shared round datapath through the inverse cipher: load round-10 key, initial AddRoundKey, 9 inverse rounds, final round.
- Generates the inverse key schedule selects, with rcon counting down.
- Adds a start/busy/done handshake. Start is gated by the key-ready flag set when encryption key expansion stores the last round key.

---
 rtl/decrypt_ctrl_fsm.sv | 108 ++++++++++
 1 files changed

// File: rtl/decrypt_ctrl_fsm.sv
// AES-128 inverse-cipher control FSM: sequences key load, initial AddRoundKey,
// nine inverse rounds and the final round, with a start/busy/done handshake.
module decrypt_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       stadec,
  input  logic       deckeyrdy,
  output logic [1:0] keysel,
  output logic       rndkren,
  output logic [3:0] rconsel,
  output logic       sboxinsel,
  output logic       wrregen,
  output logic [1:0] keyadsel,
  output logic       mixsel,
  output logic       reginsel,
  output logic       busy,
  output logic       done,
  output logic [3:0] dec_state
);

  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StKeyLoad    = 4'd1,
    StInitKeyAdd = 4'd2,
    StR9         = 4'd3,
    StR8         = 4'd4,
    StR7         = 4'd5,
    StR6         = 4'd6,
    StR5         = 4'd7,
    StR4         = 4'd8,
    StR3         = 4'd9,
    StR2         = 4'd10,
    StR1         = 4'd11,
    StLast       = 4'd12,
    StDone       = 4'd13
  } state_e;

  // Plain vector so the unused codes 14/15 are representable and recoverable.
  logic [3:0] state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: begin
        if (stadec && deckeyrdy) state_d = StKeyLoad;
      end
      StKeyLoad, StInitKeyAdd, StR9, StR8, StR7, StR6, StR5, StR4, StR3, StR2, StR1, StLast: begin
        state_d = state_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    keysel    = 2'd3;
    rndkren   = 1'b1;
    rconsel   = 4'd0;
    sboxinsel = 1'b1;
    wrregen   = 1'b1;
    keyadsel  = 2'd1;
    mixsel    = 1'b1;
    reginsel  = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    dec_state = state_q;
    case (state_q)
      StIdle: begin
        rndkren   = 1'b0;
        sboxinsel = 1'b0;
        wrregen   = 1'b0;
        mixsel    = 1'b0;
        reginsel  = 1'b0;
        busy      = 1'b0;
      end
      StKeyLoad: begin
        keysel  = 2'd1;
        wrregen = 1'b0;
      end
      StInitKeyAdd: begin
        keyadsel = 2'd0;
        rconsel  = 4'd9;
      end
      // rcon counts down so the last inverse round derives k0.
      StR9, StR8, StR7, StR6, StR5, StR4, StR3, StR2, StR1: begin
        rconsel = 4'd11 - state_q;
      end
      StLast: begin
        keyadsel = 2'd2;
        rndkren  = 1'b0;
      end
      StDone: begin
        rndkren = 1'b0;
        wrregen = 1'b0;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
